// File: rtl/sentinel_lock_if.sv
// Keypad-side bundle for sentinel_lock: digit entry strobes in, lock status out.
// The bench drives the master side; the lock core sits on the slave side.
interface sentinel_lock_if;
    logic [3:0] digit;
    logic       digit_valid;
    logic       clear;
    logic       unlock;
    logic       alarm;
    logic [2:0] fail_count;
    logic [2:0] digits_entered;

    modport master (
        output digit,
        output digit_valid,
        output clear,
        input  unlock,
        input  alarm,
        input  fail_count,
        input  digits_entered
    );

    modport slave (
        input  digit,
        input  digit_valid,
        input  clear,
        output unlock,
        output alarm,
        output fail_count,
        output digits_entered
    );
endinterface

// File: rtl/sentinel_lock.sv
// Four-digit code lock with timed unlock window and alarm lockout after
// MAX_FAILS consecutive wrong codes.
module sentinel_lock #(
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int unsigned MAX_FAILS      = 3,
    parameter logic [15:0] UNLOCK_CYCLES  = 16'd1000,
    parameter logic [15:0] LOCKOUT_CYCLES = 16'd50000
) (
    input  logic            clk,
    input  logic            r,
    sentinel_lock_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTRY    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    localparam logic [2:0]  MAX_FAILS_W  = 3'(MAX_FAILS);
    // Timers count down to zero inclusive, so a load of N-1 gives N cycles.
    localparam logic [15:0] UNLOCK_LOAD  = UNLOCK_CYCLES - 16'd1;
    localparam logic [15:0] LOCKOUT_LOAD = LOCKOUT_CYCLES - 16'd1;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [11:0] hist_r;
    logic [11:0] hist_nxt_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_nxt_s;
    logic [2:0]  fail_r;
    logic [2:0]  fail_nxt_s;
    logic [15:0] timer_r;
    logic [15:0] timer_nxt_s;
    logic [3:0]  fail_inc_s;
    logic        unlock_r;
    logic        alarm_r;

    // Next-state, history, attempt counter, failure counter and timer.
    always_comb begin
        state_nxt_s = state_r;
        hist_nxt_s  = hist_r;
        cnt_nxt_s   = cnt_r;
        fail_nxt_s  = fail_r;
        timer_nxt_s = timer_r;
        fail_inc_s  = {1'b0, fail_r} + 4'd1;

        case (state_r)
            ST_IDLE, ST_ENTRY: begin
                if (bus.clear) begin
                    state_nxt_s = ST_IDLE;
                    hist_nxt_s  = 12'd0;
                    cnt_nxt_s   = 3'd0;
                end else if (bus.digit_valid) begin
                    if (cnt_r == 3'd3) begin
                        hist_nxt_s = 12'd0;
                        cnt_nxt_s  = 3'd0;
                        if ({hist_r, bus.digit} == CODE) begin
                            state_nxt_s = ST_UNLOCKED;
                            fail_nxt_s  = 3'd0;
                            timer_nxt_s = UNLOCK_LOAD;
                        end else if (fail_inc_s < {1'b0, MAX_FAILS_W}) begin
                            state_nxt_s = ST_IDLE;
                            fail_nxt_s  = fail_inc_s[2:0];
                        end else begin
                            state_nxt_s = ST_LOCKOUT;
                            fail_nxt_s  = MAX_FAILS_W;
                            timer_nxt_s = LOCKOUT_LOAD;
                        end
                    end else begin
                        state_nxt_s = ST_ENTRY;
                        hist_nxt_s  = {hist_r[7:0], bus.digit};
                        cnt_nxt_s   = cnt_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_UNLOCKED: begin
                if (bus.clear || (timer_r == 16'd0)) begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = 16'd0;
                end else begin
                    timer_nxt_s = timer_r - 16'd1;
                end
            end
            ST_LOCKOUT: begin
                if (timer_r == 16'd0) begin
                    state_nxt_s = ST_IDLE;
                    fail_nxt_s  = 3'd0;
                end else begin
                    timer_nxt_s = timer_r - 16'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                hist_nxt_s  = 12'd0;
                cnt_nxt_s   = 3'd0;
                fail_nxt_s  = 3'd0;
                timer_nxt_s = 16'd0;
            end
        endcase
    end

    // State and datapath registers; outputs are registered from next-state.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_r  <= ST_IDLE;
            hist_r   <= 12'd0;
            cnt_r    <= 3'd0;
            fail_r   <= 3'd0;
            timer_r  <= 16'd0;
            unlock_r <= 1'b0;
            alarm_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            hist_r   <= hist_nxt_s;
            cnt_r    <= cnt_nxt_s;
            fail_r   <= fail_nxt_s;
            timer_r  <= timer_nxt_s;
            unlock_r <= (state_nxt_s == ST_UNLOCKED);
            alarm_r  <= (state_nxt_s == ST_LOCKOUT);
        end
    end

    assign bus.unlock         = unlock_r;
    assign bus.alarm          = alarm_r;
    assign bus.fail_count     = fail_r;
    assign bus.digits_entered = cnt_r;

endmodule

// File: tb/tb_sentinel_lock.sv
// Bench for sentinel_lock: hand-written vector table, reset corner cases,
// then randomized traffic against a queue-based reference model.
module tb_sentinel_lock;

    localparam int CODE_I    = 'h1234;
    localparam int MAXF_I    = 3;
    localparam int UNLOCK_I  = 8;
    localparam int LOCKOUT_I = 16;

    logic clk;
    logic r;
    sentinel_lock_if bus ();

    sentinel_lock #(
        .CODE           (16'h1234),
        .MAX_FAILS      (3),
        .UNLOCK_CYCLES  (16'd8),
        .LOCKOUT_CYCLES (16'd16)
    ) dut (
        .clk (clk),
        .r   (r),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    typedef struct {
        bit       dv;
        bit [3:0] d;
        bit       clr;
        bit       u;
        bit       a;
        int       f;
        int       de;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit dv, int d, bit clr, bit u, bit a, int f, int de);
        vec_t v;
        v.dv = dv; v.d = 4'(d); v.clr = clr;
        v.u = u; v.a = a; v.f = f; v.de = de;
        tbl.push_back(v);
    endfunction

    // Four-digit attempt: three partial rows then the compare row.
    function automatic void attempt(int d0, int d1, int d2, int d3, int f0, bit u, bit a, int f);
        add(1'b1, d0, 1'b0, 1'b0, 1'b0, f0, 1);
        add(1'b1, d1, 1'b0, 1'b0, 1'b0, f0, 2);
        add(1'b1, d2, 1'b0, 1'b0, 1'b0, f0, 3);
        add(1'b1, d3, 1'b0, u, a, f, 0);
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_outs(string tag, int u, int a, int f, int de);
        chk({tag, " unlock"}, int'(bus.unlock), u);
        chk({tag, " alarm"}, int'(bus.alarm), a);
        chk({tag, " fail_count"}, int'(bus.fail_count), f);
        chk({tag, " digits_entered"}, int'(bus.digits_entered), de);
    endtask

    task automatic apply(bit dv, int d, bit clr);
        bus.digit_valid = dv;
        bus.digit       = 4'(d);
        bus.clear       = clr;
        @(posedge clk);
        #1;
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b0;
    endtask

    // Reference model: entered digits in a queue, remaining cycles of the
    // current open or alarm window, consecutive failure tally.
    bit m_open;
    bit m_alarm;
    int m_left;
    int m_fails;
    int m_q[$];

    function automatic void m_reset();
        m_open = 1'b0; m_alarm = 1'b0; m_left = 0; m_fails = 0;
        m_q.delete();
    endfunction

    function automatic void m_step(bit dv, int d, bit clr);
        int v;
        if (m_alarm) begin
            m_left--;
            if (m_left == 0) begin
                m_alarm = 1'b0;
                m_fails = 0;
            end
        end else if (m_open) begin
            if (clr) m_open = 1'b0;
            else begin
                m_left--;
                if (m_left == 0) m_open = 1'b0;
            end
        end else if (clr) begin
            m_q.delete();
        end else if (dv) begin
            m_q.push_back(d);
            if (m_q.size() == 4) begin
                v = ((m_q[0] * 16 + m_q[1]) * 16 + m_q[2]) * 16 + m_q[3];
                m_q.delete();
                if (v == CODE_I) begin
                    m_open = 1'b1; m_left = UNLOCK_I; m_fails = 0;
                end else begin
                    m_fails++;
                    if (m_fails >= MAXF_I) begin
                        m_alarm = 1'b1; m_left = LOCKOUT_I;
                    end
                end
            end
        end
    endfunction

    // Asynchronous reset pulse between clock edges, checked before any edge.
    task automatic pulse_reset(string tag);
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b0;
        #3 r = 1'b1;
        #1;
        m_reset();
        chk_outs(tag, 0, 0, 0, 0);
        #1 r = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_reset();
        r = 1'b1;
        bus.digit = 4'd0; bus.digit_valid = 1'b0; bus.clear = 1'b0;

        // Vector table, evaluated continuously from reset.
        attempt(1, 2, 3, 4, 0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 7; i++) add(i == 2 || i == 4, (i == 2) ? 9 : 1, 1'b0, 1'b1, 1'b0, 0, 0);
        add(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        add(1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 1);
        add(1'b1, 2, 1'b0, 1'b0, 1'b0, 0, 2);
        add(1'b1, 3, 1'b1, 1'b0, 1'b0, 0, 0);
        attempt(1, 2, 3, 4, 0, 1'b1, 1'b0, 0);
        add(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        add(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        add(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0);
        add(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        attempt(1, 2, 3, 5, 0, 1'b0, 1'b0, 1);
        attempt(9, 9, 9, 9, 1, 1'b0, 1'b0, 2);
        attempt(1, 2, 3, 4, 2, 1'b1, 1'b0, 0);
        add(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0);
        attempt(1, 2, 3, 5, 0, 1'b0, 1'b0, 1);
        attempt(1, 2, 3, 5, 1, 1'b0, 1'b0, 2);
        attempt(1, 2, 3, 5, 2, 1'b0, 1'b1, 3);
        for (int i = 0; i < 15; i++)
            add(i >= 2 && i < 6, i - 1, i == 8, 1'b0, 1'b1, 3, 0);
        add(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        attempt(1, 2, 3, 4, 0, 1'b1, 1'b0, 0);
        add(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0);
        r = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].dv, int'(tbl[i].d), tbl[i].clr);
            chk_outs($sformatf("row%0d", i), int'(tbl[i].u), int'(tbl[i].a), tbl[i].f, tbl[i].de);
        end

        // Async reset in the middle of lockout, then immediate re-entry.
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1, 1'b0); apply(1'b1, 2, 1'b0);
            apply(1'b1, 3, 1'b0); apply(1'b1, 6, 1'b0);
        end
        chk_outs("lockout entered", 0, 1, 3, 0);
        repeat (4) apply(1'b0, 0, 1'b0);
        pulse_reset("reset mid lockout");
        apply(1'b1, 1, 1'b0);
        chk_outs("first digit after reset", 0, 0, 0, 1);
        apply(1'b1, 2, 1'b0); apply(1'b1, 3, 1'b0); apply(1'b1, 4, 1'b0);
        chk_outs("unlock after reset", 1, 0, 0, 0);
        repeat (3) apply(1'b0, 0, 1'b0);

        // Reset mid-unlock and mid-entry leaves nothing behind.
        pulse_reset("reset mid unlock");
        apply(1'b1, 1, 1'b0); apply(1'b1, 2, 1'b0);
        pulse_reset("reset mid entry");
        apply(1'b1, 3, 1'b0); apply(1'b1, 4, 1'b0);
        chk_outs("no residual history", 0, 0, 0, 2);
        apply(1'b0, 0, 1'b1);
        chk_outs("clear from entry", 0, 0, 0, 0);

        // Randomized traffic against the reference model.
        pulse_reset("random start");
        for (int n = 0; n < 3000; n++) begin
            bit dv;
            bit clr;
            int d;
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset($sformatf("rnd%0d reset", n));
            end else begin
                dv  = ($urandom_range(0, 2) != 0);
                clr = ($urandom_range(0, 29) == 0);
                if (!m_open && !m_alarm && $urandom_range(0, 4) != 0)
                    d = (CODE_I >> (4 * (3 - m_q.size()))) & 15;
                else
                    d = int'($urandom_range(0, 15));
                apply(dv, d, clr);
                m_step(dv, d, clr);
                chk_outs($sformatf("rnd%0d", n), int'(m_open), int'(m_alarm), m_fails, m_q.size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sentinel_lock.md
SENTINEL_LOCK -- requirements
Module: sentinel_lock

Interface
REQ-001 Parameter CODE, default 16'h1234: four 4-bit access digits; first-entered digit in CODE[15:12].
REQ-002 Parameter MAX_FAILS, default 3: consecutive failed attempts that trigger lockout; legal range 1..7.
REQ-003 Parameter UNLOCK_CYCLES, default 16'd1000: clock cycles unlock stays asserted; legal range 1..65535.
REQ-004 Parameter LOCKOUT_CYCLES, default 16'd50000: clock cycles of alarm lockout; legal range 1..65535.
REQ-005 clk  input  1  rising-edge system clock; sole clock.
REQ-006 r  input  1  asynchronous active-high reset.
REQ-007 digit  input  4  entered digit; sampled only when digit_valid=1.
REQ-008 digit_valid  input  1  single-cycle strobe qualifying digit.
REQ-009 clear  input  1  abort partial entry or end unlock early; level-sampled each edge.
REQ-010 unlock  output  1  registered; high while state=UNLOCKED.
REQ-011 alarm  output  1  registered; high while state=LOCKOUT.
REQ-012 fail_count  output  3  registered; consecutive failed attempts since last success or lockout expiry.
REQ-013 digits_entered  output  3  registered; digits accepted in current attempt, 0..3.

Function
REQ-014 FSM states SHALL be IDLE, ENTRY, UNLOCKED, LOCKOUT; all transitions on rising clk.
REQ-015 In IDLE or ENTRY with digit_valid=1 and clear=0, digit SHALL shift into a 12-bit history register (newest in LSBs) and digits_entered SHALL increment; IDLE moves to ENTRY.
REQ-016 On acceptance of the fourth digit, the SHALL compare {history, digit} against CODE in that same edge; digits_entered returns to 0.
REQ-017 Match: next state UNLOCKED, fail_count cleared to 0, unlock high the cycle after the fourth-digit edge (1-cycle latency).
REQ-018 Mismatch with fail_count+1 < MAX_FAILS: fail_count increments, next state IDLE.
REQ-019 Mismatch with fail_count+1 = MAX_FAILS: fail_count set to MAX_FAILS, next state LOCKOUT, alarm high the following cycle.
REQ-020 UNLOCKED SHALL last exactly UNLOCK_CYCLES cycles (down-counter loaded on entry), then IDLE; digit_valid ignored.
REQ-021 clear=1 in UNLOCKED SHALL return to IDLE on the next edge; unlock low the following cycle.
REQ-022 clear=1 in ENTRY SHALL discard history, set digits_entered to 0, go IDLE; fail_count unchanged.
REQ-023 clear and digit_valid in the same cycle: clear wins, digit dropped, no compare performed.
REQ-024 LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles, ignoring digit_valid and clear, then IDLE with fail_count cleared to 0.
REQ-025 unlock and alarm SHALL never be high simultaneously; both low in IDLE and ENTRY.
REQ-026 Timer reaching 0 SHALL not wrap; the expiry edge performs the state exit.
REQ-027 Partial entry has no timeout; only clear or reset abandons it.

Reset
REQ-028 r=1 SHALL immediately force IDLE, unlock=0, alarm=0, fail_count=0, digits_entered=0, history=0, timers=0, independent of clk.
REQ-029 Reset asserted mid-entry, mid-unlock or mid-lockout SHALL abandon that operation with no residual state after release.
REQ-030 First digit SHALL be accepted on the first rising edge after r deasserts.

Verification (CODE=16'h1234, MAX_FAILS=3, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16)
REQ-031 Digits 1,2,3,4 on consecutive strobes -> unlock=1 one cycle after 4th strobe, stays high exactly 8 cycles, fail_count=0.
REQ-032 Three attempts 1,2,3,5 -> fail_count 1,2,3; alarm=1 for exactly 16 cycles; code 1,2,3,4 during lockout ignored; then fail_count=0, IDLE.
REQ-033 Digits 1,2 then clear coincident with digit 3 -> digits_entered=0, no compare; subsequent 1,2,3,4 unlocks.
REQ-034 Correct code, clear asserted 3 cycles into unlock -> unlock low the cycle after clear edge, state IDLE.
REQ-035 Two failures then correct code -> unlock=1, fail_count=0.
REQ-036 r pulsed asynchronously during lockout (between edges) -> alarm=0 and fail_count=0 immediately; 1,2,3,4 after release unlocks.
